// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard controller: tracks EX/MEM destinations, drives the WB-to-ID
// register-file bypass select, stalls ID on uncoverable RAW hazards and sequences mult/div.
module id_hazard_scoreboard #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Valid_ID,
  input  logic [4:0] Read_Address_1_ID,
  input  logic [4:0] Read_Address_2_ID,
  input  logic       Uses_Rs_ID,
  input  logic       Uses_Rt_ID,
  input  logic [4:0] Dest_Register_ID,
  input  logic       RegWrite_ID,
  input  logic       MultDiv_ID,
  input  logic       Reads_HILO_ID,
  input  logic       Hold,
  input  logic [4:0] Write_Register_WB,
  input  logic       RegWrite_WB,
  output logic       Stall_ID,
  output logic [1:0] ID_Register_Write_to_Read,
  output logic       MD_Busy,
  output logic       MD_Done
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             ex_valid_q;
  logic [4:0]       ex_dest_q;
  logic             mem_valid_q;
  logic [4:0]       mem_dest_q;
  md_state_t        state_q;
  logic [CNT_W-1:0] count_q;
  logic             md_done_q;

  logic             byp_rs;
  logic             byp_rt;
  logic             haz_ex;
  logic             haz_mem;
  logic             md_haz;
  logic             stall;
  logic             issue;
  logic             ex_valid_d;

  always_comb begin
    byp_rs = RegWrite_WB && (Write_Register_WB != 5'd0) &&
             (Write_Register_WB == Read_Address_1_ID);
    byp_rt = RegWrite_WB && (Write_Register_WB != 5'd0) &&
             (Write_Register_WB == Read_Address_2_ID);

    // Tracked destinations are never r0, so reads of r0 cannot match a valid entry.
    haz_ex  = ex_valid_q &&
              ((Uses_Rs_ID && (Read_Address_1_ID == ex_dest_q)) ||
               (Uses_Rt_ID && (Read_Address_2_ID == ex_dest_q)));
    haz_mem = mem_valid_q &&
              ((Uses_Rs_ID && (Read_Address_1_ID == mem_dest_q)) ||
               (Uses_Rt_ID && (Read_Address_2_ID == mem_dest_q)));

    // HI/LO is readable during DONE, so only BUSY blocks mult/div users.
    md_haz = (state_q == MD_BUSY) && (MultDiv_ID || Reads_HILO_ID);

    stall      = Valid_ID && (haz_ex || haz_mem || md_haz);
    issue      = Valid_ID && MultDiv_ID && !stall;
    ex_valid_d = Valid_ID && RegWrite_ID && (Dest_Register_ID != 5'd0);
  end

  assign ID_Register_Write_to_Read = {byp_rt, byp_rs};
  assign Stall_ID                  = stall;
  assign MD_Busy                   = (state_q != MD_IDLE);
  assign MD_Done                   = md_done_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_q  <= 1'b0;
      ex_dest_q   <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= 5'd0;
    end else if (!Hold) begin
      mem_valid_q <= ex_valid_q;
      mem_dest_q  <= ex_dest_q;
      if (stall) begin
        ex_valid_q <= 1'b0;
      end else begin
        ex_valid_q <= ex_valid_d;
        ex_dest_q  <= Dest_Register_ID;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      md_done_q <= 1'b0;
    end else if (Hold) begin
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          md_done_q <= 1'b0;
          if (issue) begin
            state_q <= MD_BUSY;
            count_q <= MD_LOAD;
          end
        end
        MD_BUSY: begin
          count_q <= count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_q   <= MD_DONE;
            md_done_q <= 1'b1;
          end else begin
            md_done_q <= 1'b0;
          end
        end
        MD_DONE: begin
          md_done_q <= 1'b0;
          if (issue) begin
            state_q <= MD_BUSY;
            count_q <= MD_LOAD;
          end else begin
            state_q <= MD_IDLE;
          end
        end
        default: begin
          state_q   <= MD_IDLE;
          count_q   <= '0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: per-cycle stimulus with expected outputs queued
// alongside, compared at the falling edge as {Stall_ID, bypass[1:0], MD_Busy, MD_Done}.
module tb_id_hazard_scoreboard;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Valid_ID;
  logic [4:0] Read_Address_1_ID;
  logic [4:0] Read_Address_2_ID;
  logic       Uses_Rs_ID;
  logic       Uses_Rt_ID;
  logic [4:0] Dest_Register_ID;
  logic       RegWrite_ID;
  logic       MultDiv_ID;
  logic       Reads_HILO_ID;
  logic       Hold;
  logic [4:0] Write_Register_WB;
  logic       RegWrite_WB;
  logic       Stall_ID;
  logic [1:0] ID_Register_Write_to_Read;
  logic       MD_Busy;
  logic       MD_Done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic       hold;
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       md;
    logic       hilo;
    logic [4:0] wbr;
    logic       wbw;
  } stim_t;

  logic [4:0] exp_q[$];

  id_hazard_scoreboard #(.MD_LATENCY(4), .CNT_W(8)) dut (
    .Clk                       (Clk),
    .Reset                     (Reset),
    .Valid_ID                  (Valid_ID),
    .Read_Address_1_ID         (Read_Address_1_ID),
    .Read_Address_2_ID         (Read_Address_2_ID),
    .Uses_Rs_ID                (Uses_Rs_ID),
    .Uses_Rt_ID                (Uses_Rt_ID),
    .Dest_Register_ID          (Dest_Register_ID),
    .RegWrite_ID               (RegWrite_ID),
    .MultDiv_ID                (MultDiv_ID),
    .Reads_HILO_ID             (Reads_HILO_ID),
    .Hold                      (Hold),
    .Write_Register_WB         (Write_Register_WB),
    .RegWrite_WB               (RegWrite_WB),
    .Stall_ID                  (Stall_ID),
    .ID_Register_Write_to_Read (ID_Register_Write_to_Read),
    .MD_Busy                   (MD_Busy),
    .MD_Done                   (MD_Done)
  );

  always #5 Clk = ~Clk;

  function automatic stim_t st(logic rst, logic hold, logic vld, logic [4:0] rs,
                               logic [4:0] rt, logic urs, logic urt, logic [4:0] dst,
                               logic rw, logic md, logic hilo, logic [4:0] wbr, logic wbw);
    stim_t s;
    s.rst = rst; s.hold = hold; s.vld = vld; s.rs = rs; s.rt = rt;
    s.urs = urs; s.urt = urt; s.dst = dst; s.rw = rw; s.md = md;
    s.hilo = hilo; s.wbr = wbr; s.wbw = wbw;
    return s;
  endfunction

  function automatic stim_t idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input stim_t s);
    Reset             = s.rst;
    Hold              = s.hold;
    Valid_ID          = s.vld;
    Read_Address_1_ID = s.rs;
    Read_Address_2_ID = s.rt;
    Uses_Rs_ID        = s.urs;
    Uses_Rt_ID        = s.urt;
    Dest_Register_ID  = s.dst;
    RegWrite_ID       = s.rw;
    MultDiv_ID        = s.md;
    Reads_HILO_ID     = s.hilo;
    Write_Register_WB = s.wbr;
    RegWrite_WB       = s.wbw;
  endtask

  task automatic test_reset();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,3,4,1,1,3,1,0,1,0,0)); e.push_back(5'b00000);
    s.push_back(idle());                        e.push_back(5'b00000);
    s.push_back(idle());                        e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_raw();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,1,2,1,1,5,1,0,0,0,0)); e.push_back(5'b00000);
    s.push_back(st(0,0,1,5,2,1,1,6,1,0,0,0,0)); e.push_back(5'b10000);
    s.push_back(st(0,0,1,5,2,1,1,6,1,0,0,5,1)); e.push_back(5'b10100);
    s.push_back(st(0,0,1,5,2,1,1,6,1,0,0,5,1)); e.push_back(5'b00100);
    s.push_back(idle());                        e.push_back(5'b00000);
    s.push_back(idle());                        e.push_back(5'b00000);
    s.push_back(idle());                        e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL raw step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_bypass();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,0,0,1,1,0,0,0,0,0,1)); e.push_back(5'b00000);
    s.push_back(st(0,0,1,7,7,1,1,0,0,0,0,7,1)); e.push_back(5'b01100);
    s.push_back(st(0,0,0,7,7,0,0,0,0,0,0,7,1)); e.push_back(5'b01100);
    s.push_back(st(0,0,1,7,3,1,1,0,0,0,0,7,0)); e.push_back(5'b00000);
    s.push_back(st(0,0,1,2,7,1,1,0,0,0,0,7,1)); e.push_back(5'b01000);
    s.push_back(st(0,0,1,9,2,1,1,0,0,0,0,9,1)); e.push_back(5'b00100);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bypass step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_r0_writer();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,1,1,1,1,0,1,0,0,0,0)); e.push_back(5'b00000);
    s.push_back(st(0,0,1,0,0,1,1,4,0,0,0,0,0)); e.push_back(5'b00000);
    s.push_back(st(0,0,1,0,0,1,1,4,0,0,0,0,0)); e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL r0_writer step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_multdiv();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,1,2,1,1,0,0,1,0,0,0)); e.push_back(5'b00000);
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(0,0,1,0,0,0,0,8,1,0,1,0,0)); e.push_back(5'b10010);
    end
    s.push_back(st(0,0,1,0,0,0,0,8,1,0,1,0,0)); e.push_back(5'b00011);
    s.push_back(idle());                        e.push_back(5'b00000);
    s.push_back(idle());                        e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL multdiv step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,0,0,0,0,0,0,1,0,0,0)); e.push_back(5'b00000);
    for (int k = 0; k < 3; k++) begin
      s.push_back(idle()); e.push_back(5'b00010);
    end
    s.push_back(st(0,0,1,0,0,0,0,0,0,1,0,0,0)); e.push_back(5'b00011);
    for (int k = 0; k < 3; k++) begin
      s.push_back(idle()); e.push_back(5'b00010);
    end
    s.push_back(idle()); e.push_back(5'b00011);
    s.push_back(idle()); e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_hold();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,0,0,0,0,0,0,1,0,0,0)); e.push_back(5'b00000);
    s.push_back(st(0,0,1,1,2,1,1,9,1,0,0,0,0)); e.push_back(5'b00010);
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(0,1,1,9,0,1,0,0,0,0,0,0,0)); e.push_back(5'b10010);
    end
    s.push_back(st(0,0,1,9,0,1,0,0,0,0,0,0,0)); e.push_back(5'b10010);
    s.push_back(st(0,0,1,9,0,1,0,0,0,0,0,0,0)); e.push_back(5'b10010);
    s.push_back(st(0,0,1,9,0,1,0,0,0,0,0,0,0)); e.push_back(5'b00011);
    s.push_back(idle());                        e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hold step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid_busy();
    stim_t s[$]; logic [4:0] e[$]; logic [4:0] obs, exp;
    s.push_back(st(0,0,1,0,0,0,0,0,0,1,0,0,0));  e.push_back(5'b00000);
    s.push_back(st(0,0,1,1,2,1,1,12,1,0,0,0,0)); e.push_back(5'b00010);
    s.push_back(st(1,0,1,12,0,1,0,0,0,1,1,0,0)); e.push_back(5'b10010);
    s.push_back(st(0,0,1,12,0,1,0,0,0,0,1,0,0)); e.push_back(5'b00000);
    s.push_back(idle());                         e.push_back(5'b00000);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]); exp_q.push_back(e[i]);
      @(negedge Clk);
      exp = exp_q.pop_front();
      obs = {Stall_ID, ID_Register_Write_to_Read, MD_Busy, MD_Done};
      n_assert++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_busy step %0d: got %b expected %b", i, obs, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(idle());
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_raw();
    test_bypass();
    test_r0_writer();
    test_multdiv();
    test_back_to_back();
    test_hold();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
